// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: owns the PC, issues req/ack fetches and buffers returned instructions for decode.
// Optional macro FETCH_STATS_EN adds push/redirect counters on stat_fetched/stat_flushed.
module fetch_queue_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              Clock,
    input  logic              Reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              Jump,
    input  logic [25:0]       jump_index,
    input  logic              Branch,
    input  logic              Zero,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [ADDR_W-1:0] br_imm,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]       stat_fetched,
    output logic [31:0]       stat_flushed
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {FETCH, WAIT, DROP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  rdPtr_q, wrPtr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] dataMem [DEPTH];
    logic [ADDR_W-1:0] pcMem [DEPTH];

    logic              redirect, full, push, pop;
    logic [ADDR_W-1:0] brPcPlus4, branchTarget, jumpTarget, redirectTarget;

    assign redirect     = Jump | (Branch & Zero);
    assign brPcPlus4    = br_pc + ADDR_W'(4);
    assign branchTarget = brPcPlus4 + (br_imm << 2);

    generate
        if (ADDR_W > 28) begin : g_jumpHi
            assign jumpTarget = {brPcPlus4[ADDR_W-1:28], jump_index, 2'b00};
        end else begin : g_jumpLo
            assign jumpTarget = {jump_index, 2'b00};
        end
    endgenerate

    assign redirectTarget = Jump ? jumpTarget : branchTarget;

    assign full       = (count_q == CNT_W'(DEPTH));
    assign inst_valid = (count_q != '0);
    assign inst_data  = inst_valid ? dataMem[rdPtr_q] : '0;
    assign inst_pc    = inst_valid ? pcMem[rdPtr_q]   : '0;
    assign pop        = inst_valid & inst_ready;
    // A request is only ever issued with room in the queue, so a push normally never meets a full queue.
    assign push       = (state_q == WAIT) & imem_ack & ~redirect & (~full | pop);

    assign imem_req  = ~Reset & (state_q == FETCH) & ~full;
    assign imem_addr = {pc_q[ADDR_W-1:2], 2'b00};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            FETCH: begin
                if (redirect) state_d = imem_req ? DROP : FETCH;
                else if (imem_req) state_d = WAIT;
            end
            WAIT: begin
                if (redirect) state_d = imem_ack ? FETCH : DROP;
                else if (imem_ack) state_d = FETCH;
            end
            DROP: begin
                // A redirect while dropping keeps dropping unless the squashed ack has just arrived.
                if (imem_ack) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
        if (redirect) pc_d = redirectTarget;
        else if (push) pc_d = pc_q + ADDR_W'(4);
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else if (redirect) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            if (push) wrPtr_q <= wrPtr_q + PTR_W'(1);
            if (pop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset && push) begin
            dataMem[wrPtr_q] <= imem_rdata;
            pcMem[wrPtr_q]   <= pc_q;
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            stat_fetched <= '0;
            stat_flushed <= '0;
        end else begin
            if (push)     stat_fetched <= stat_fetched + 32'd1;
            if (redirect) stat_flushed <= stat_flushed + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: a one-cycle-ack memory model plus hand-computed expectations.
module tb_fetch_queue_unit;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        Jump;
    logic [25:0] jump_index;
    logic        Branch;
    logic        Zero;
    logic [31:0] br_pc;
    logic [31:0] br_imm;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_flushed;
`endif

    int checks   = 0;
    int failures = 0;

    logic        ackEn;
    logic        memPending = 1'b0;
    logic [31:0] memAddr    = '0;

    fetch_queue_unit dut (
        .Clock(Clock), .Reset(Reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .Jump(Jump), .jump_index(jump_index),
        .Branch(Branch), .Zero(Zero),
        .br_pc(br_pc), .br_imm(br_imm),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc)
`ifdef FETCH_STATS_EN
        , .stat_fetched(stat_fetched), .stat_flushed(stat_flushed)
`endif
    );

    always #5 Clock = ~Clock;

    // Memory model: holds one outstanding request and acks it whenever ackEn is high.
    always @(posedge Clock) begin
        if (imem_req) begin
            memPending <= 1'b1;
            memAddr    <= imem_addr;
        end else if (imem_ack) begin
            memPending <= 1'b0;
        end
    end
    assign imem_ack   = memPending & ackEn;
    assign imem_rdata = memAddr ^ 32'hA5A5A5A5;

    task automatic tick(input int n = 1);
        repeat (n) @(negedge Clock);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic j, input logic b, input logic z, input logic [25:0] idx,
                                 input logic [31:0] pcIn, input logic [31:0] imm);
        Jump = j; Branch = b; Zero = z; jump_index = idx; br_pc = pcIn; br_imm = imm;
    endtask

    task automatic applyReset();
        Reset = 1'b1;
        tick(2);
        checkOutput("rst_req", {31'b0, imem_req}, 32'd0);
        checkOutput("rst_valid", {31'b0, inst_valid}, 32'd0);
        checkOutput("rst_data", inst_data, 32'd0);
        checkOutput("rst_pc", inst_pc, 32'd0);
        Reset = 1'b0;
        #1;
        checkOutput("rst_rel_req", {31'b0, imem_req}, 32'd1);
        checkOutput("rst_rel_addr", imem_addr, 32'd0);
    endtask

    initial begin
        Reset = 1'b1; ackEn = 1'b1; inst_ready = 1'b1;
        applyStimulus(0, 0, 0, '0, '0, '0);
        tick(1);

        $display("[TB] sequential fetch with ready=1");
        applyReset();
        tick(1);
        checkOutput("seq_wait_req", {31'b0, imem_req}, 32'd0);
        checkOutput("seq_wait_valid", {31'b0, inst_valid}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            checkOutput("seq_valid", {31'b0, inst_valid}, 32'd1);
            checkOutput("seq_pc", inst_pc, 32'(4 * k));
            checkOutput("seq_data", inst_data, 32'(4 * k) ^ 32'hA5A5A5A5);
            checkOutput("seq_addr", imem_addr, 32'(4 * k + 4));
            tick(1);
            checkOutput("seq_gap_valid", {31'b0, inst_valid}, 32'd0);
        end

        $display("[TB] backpressure fills queue");
        inst_ready = 1'b0;
        applyReset();
        tick(8);
        checkOutput("full_valid", {31'b0, inst_valid}, 32'd1);
        checkOutput("full_head", inst_pc, 32'h0);
        checkOutput("full_req", {31'b0, imem_req}, 32'd0);
        tick(1);
        checkOutput("full_hold_req", {31'b0, imem_req}, 32'd0);
        checkOutput("full_hold_pc", inst_pc, 32'h0);
        checkOutput("full_hold_data", inst_data, 32'hA5A5A5A5);
        inst_ready = 1'b1;
        tick(1);
        checkOutput("drain_pc1", inst_pc, 32'h4);
        checkOutput("drain_req", {31'b0, imem_req}, 32'd1);
        checkOutput("drain_addr", imem_addr, 32'h10);
        tick(1);
        checkOutput("drain_pc2", inst_pc, 32'h8);
        tick(1);
        checkOutput("drain_pc3", inst_pc, 32'hC);
        tick(1);
        checkOutput("resume_pc", inst_pc, 32'h10);
        checkOutput("resume_data", inst_data, 32'hA5A5A5B5);

        $display("[TB] taken branch during WAIT with same-cycle ack");
        inst_ready = 1'b0;
        applyReset();
        tick(5);
        checkOutput("br_pre_addr", imem_addr, 32'h8);
        checkOutput("br_pre_req", {31'b0, imem_req}, 32'd0);
        checkOutput("br_pre_head", inst_pc, 32'h0);
        applyStimulus(0, 1, 1, '0, 32'h4, 32'd3);
        tick(1);
        applyStimulus(0, 0, 0, '0, '0, '0);
        checkOutput("br_flush_valid", {31'b0, inst_valid}, 32'd0);
        checkOutput("br_req", {31'b0, imem_req}, 32'd1);
        checkOutput("br_addr", imem_addr, 32'h14);
        tick(1);
        checkOutput("br_wait_valid", {31'b0, inst_valid}, 32'd0);
        tick(1);
        checkOutput("br_head_pc", inst_pc, 32'h14);
        checkOutput("br_head_data", inst_data, 32'hA5A5A5B1);

        $display("[TB] jump beats branch, redirect from FETCH");
        applyStimulus(1, 1, 1, 26'h40, 32'h1000_0000, 32'd5);
        tick(1);
        applyStimulus(0, 0, 0, '0, '0, '0);
        checkOutput("jmp_flush_valid", {31'b0, inst_valid}, 32'd0);
        checkOutput("jmp_drop_req", {31'b0, imem_req}, 32'd0);
        tick(1);
        checkOutput("jmp_req", {31'b0, imem_req}, 32'd1);
        checkOutput("jmp_addr", imem_addr, 32'h1000_0100);
        tick(2);
        checkOutput("jmp_head_pc", inst_pc, 32'h1000_0100);
        checkOutput("jmp_head_data", inst_data, 32'hB5A5A4A5);

        $display("[TB] branch target wrap with delayed ack");
        ackEn = 1'b0;
        tick(1);
        checkOutput("wrap_wait_req", {31'b0, imem_req}, 32'd0);
        applyStimulus(0, 1, 1, '0, 32'hFFFF_FFF8, 32'd1);
        tick(1);
        applyStimulus(0, 0, 0, '0, '0, '0);
        checkOutput("wrap_flush_valid", {31'b0, inst_valid}, 32'd0);
        checkOutput("wrap_drop_req", {31'b0, imem_req}, 32'd0);
        tick(1);
        checkOutput("wrap_drop_hold", {31'b0, imem_req}, 32'd0);
        ackEn = 1'b1;
        tick(1);
        checkOutput("wrap_req", {31'b0, imem_req}, 32'd1);
        checkOutput("wrap_addr", imem_addr, 32'h0);
        tick(1);
        checkOutput("wrap_discard_valid", {31'b0, inst_valid}, 32'd0);
        tick(1);
        checkOutput("wrap_head_pc", inst_pc, 32'h0);
        checkOutput("wrap_head_data", inst_data, 32'hA5A5A5A5);

        $display("[TB] reset in WAIT with three queued entries");
        tick(5);
        checkOutput("rw_valid", {31'b0, inst_valid}, 32'd1);
        checkOutput("rw_addr", imem_addr, 32'hC);
        checkOutput("rw_ack", {31'b0, imem_ack}, 32'd1);
        applyReset();
        tick(1);
        checkOutput("rw_stale_valid", {31'b0, inst_valid}, 32'd0);
        tick(1);
        checkOutput("rw_head_pc", inst_pc, 32'h0);
        checkOutput("rw_head_data", inst_data, 32'hA5A5A5A5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
